// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: streams words from a combinational instruction memory into a 2-entry buffer.
// Latency 1 cycle from fetch edge to instr_o; stalls fetch when the buffer is full and ready_i is low.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned INSTR_MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [1:0]  count_o,
  output logic        err_o,
  output logic        align_err_o
);

  localparam logic [31:0] LAST_PC = 32'(INSTR_MEM_BYTES - 4);

  logic [31:0] pc_q;
  logic [31:0] head_pc_q;
  logic [31:0] head_instr_q;
  logic [31:0] tail_pc_q;
  logic [31:0] tail_instr_q;
  logic [1:0]  count_q;
  logic        err_q;
  logic        align_err_q;

  logic pop;
  logic in_range;
  logic fetch;

  assign pop      = (count_q != 2'd0) && ready_i;
  assign in_range = (pc_q <= LAST_PC);
  assign fetch    = !redirect_i && !err_q && in_range && ((count_q != 2'd2) || pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
      count_q      <= 2'd0;
      err_q        <= 1'b0;
      align_err_q  <= 1'b0;
    end else if (redirect_i) begin
      // Redirect wins over everything, including a pop in the same cycle.
      count_q     <= 2'd0;
      pc_q        <= {redirect_pc_i[31:2], 2'b00};
      err_q       <= 1'b0;
      align_err_q <= |redirect_pc_i[1:0];
    end else begin
      align_err_q <= 1'b0;
      if (!err_q && !in_range) begin
        err_q <= 1'b1;
      end
      if (fetch) begin
        pc_q <= pc_q + 32'd4;
      end
      if (fetch && !pop) begin
        if (count_q == 2'd0) begin
          head_pc_q    <= pc_q;
          head_instr_q <= instr_i;
        end else begin
          tail_pc_q    <= pc_q;
          tail_instr_q <= instr_i;
        end
        count_q <= count_q + 2'd1;
      end else if (fetch && pop) begin
        // Push and pop together: occupancy unchanged, tail shifts into head.
        if (count_q == 2'd2) begin
          head_pc_q    <= tail_pc_q;
          head_instr_q <= tail_instr_q;
          tail_pc_q    <= pc_q;
          tail_instr_q <= instr_i;
        end else begin
          head_pc_q    <= pc_q;
          head_instr_q <= instr_i;
        end
      end else if (pop) begin
        head_pc_q    <= tail_pc_q;
        head_instr_q <= tail_instr_q;
        count_q      <= count_q - 2'd1;
      end
    end
  end

  assign pc_o        = pc_q;
  assign count_o     = count_q;
  assign valid_o     = (count_q != 2'd0);
  assign instr_o     = valid_o ? head_instr_q : 32'd0;
  assign instr_pc_o  = valid_o ? head_pc_q : 32'd0;
  assign err_o       = err_q;
  assign align_err_o = align_err_q;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL have parameter INSTR_MEM_BYTES, default 1024, byte size of the instruction memory it drives.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pc_o  output  32  byte address driven to the instruction memory pc_addr_i.
REQ-006 SHALL have port instr_i  input  32  big-endian word returned combinationally by the instruction memory for pc_o.
REQ-007 SHALL have port redirect_i  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc_i  input  32  redirect target byte address.
REQ-009 SHALL have port ready_i  input  1  decode stage accepts the head entry.
REQ-010 SHALL have port valid_o  output  1  head entry present.
REQ-011 SHALL have port instr_o  output  32  head entry instruction word.
REQ-012 SHALL have port instr_pc_o  output  32  head entry fetch address.
REQ-013 SHALL have port count_o  output  2  buffer occupancy, 0..2.
REQ-014 SHALL have port err_o  output  1  sticky out-of-range fetch flag.
REQ-015 SHALL have port align_err_o  output  1  one-cycle pulse on misaligned redirect target.

Function
REQ-016 SHALL hold a 2-entry in-order FIFO of {fetch address, instruction word}.
REQ-017 SHALL define pop = valid_o AND ready_i; valid_o = (count_o != 0); instr_o/instr_pc_o = head entry, both 0 when empty.
REQ-018 SHALL define in_range = (pc_o <= INSTR_MEM_BYTES-4).
REQ-019 SHALL define fetch = NOT redirect_i AND NOT err_o AND in_range AND (count_o < 2 OR pop).
REQ-020 SHALL, on fetch, push {pc_o, instr_i} and update pc_o to pc_o+4, modulo 2^32.
REQ-021 SHALL, without fetch and without redirect, hold pc_o.
REQ-022 SHALL, on simultaneous push and pop, keep count_o unchanged with FIFO order preserved; at count 1 the new entry becomes head.
REQ-023 SHALL, at count_o=2 with no pop, push nothing and hold pc_o (full stall).
REQ-024 SHALL, on redirect_i, on the next edge:
- set count_o to 0, discarding all entries including any popped this cycle;
- set pc_o to {redirect_pc_i[31:2], 2'b00};
- clear err_o.
REQ-025 SHALL, on redirect_i with redirect_pc_i[1:0] != 0, assert align_err_o for exactly the following cycle.
REQ-026 SHALL, when not in_range and neither redirect_i nor err_o is asserted, set err_o on the next edge, push nothing, and hold pc_o.
REQ-027 SHALL, while err_o is set, continue to drain the buffer through pop.
REQ-028 SHALL have first-word latency of 1 cycle: a word fetched at edge N is visible on instr_o after edge N.
REQ-029 SHALL sustain one pop per cycle with ready_i held high.

Reset
REQ-030 SHALL, while rst_i is high, asynchronously force:
- pc_o=RESET_PC;
- count_o=0, valid_o=0;
- instr_o=0, instr_pc_o=0;
- err_o=0, align_err_o=0.
REQ-031 SHALL, on reset mid-operation, discard buffered entries and any pending redirect; fetching resumes at RESET_PC on the first edge after rst_i falls.

Verification
REQ-032 SHALL cover streaming: reset release, ready_i=1, memory words 0x11111111, 0x22222222 at 0x0, 0x4 -> instr_pc_o/instr_o = 0x0/0x11111111, then 0x4/0x22222222 on consecutive cycles; valid_o stays high.
REQ-033 SHALL cover backpressure: ready_i=0 for 5 cycles -> count_o reaches 2 and stays; pc_o holds 0x8; then ready_i=1 -> entries 0x0, 0x4, 0x8 emitted in order with no loss or duplication.
REQ-034 SHALL cover redirect: count_o=2, redirect_i=1 with redirect_pc_i=0x100 -> next cycle count_o=0, pc_o=0x100; the following cycle head instr_pc_o=0x100.
REQ-035 SHALL cover misaligned redirect: redirect_pc_i=0x0206 -> pc_o=0x204; align_err_o high for exactly one cycle.
REQ-036 SHALL cover out of range: redirect to 0x3FC with INSTR_MEM_BYTES=1024 -> entry 0x3FC fetched; pc_o=0x400; err_o set next edge; no further pushes; a redirect to 0x0 clears err_o.
REQ-037 SHALL cover reset mid-stream: rst_i pulsed asynchronously between edges with count_o=2 -> count_o=0, pc_o=RESET_PC immediately without waiting for a clock edge.
